axi_single_beat_master: RTL
===========================

// Module: axi_single_beat_master
// PURPOSE
//  Initiator-side AXI4 bridge: converts a simple one-request-at-a-time memory port (CPU IM/DM side)
//  into single-beat AXI read (AR/R) or write (AW/W/B) transactions toward the interconnect.
//  Drives the same bus that the SRAM/peripheral slave wrappers respond on. One outstanding transaction max.
// PARAMETERS
//  MASTER_ID  4'd0  value driven on ARID/AWID; RID/BID are not checked
// PORTS
//  CLK        in   1   clock; all logic rising-edge
//  RST        in   1   reset, asynchronous, active-high
//  req_valid  in   1   request present
//  req_write  in   1   1=write, 0=read
//  req_addr   in   32  byte address, forwarded unmodified
//  req_wdata  in   32  write data
//  req_wstrb  in   4   byte enables
//  req_ready  out  1   request accepted this cycle (req_valid&req_ready)
//  resp_valid out  1   one-cycle completion pulse
//  resp_rdata out  32  read data, valid with resp_valid on reads; holds last value otherwise
//  resp_err   out  1   RRESP/BRESP != OKAY, valid with resp_valid
//  ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID out 4/32/4/3/2/1; ARREADY in 1
//  RID/RDATA/RRESP/RLAST/RVALID in 4/32/2/1/1; RREADY out 1
//  AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID out 4/32/4/3/2/1; AWREADY in 1
//  WDATA/WSTRB/WLAST/WVALID out 32/4/1/1; WREADY in 1
//  BID/BRESP/BVALID in 4/2/1; BREADY out 1
// BEHAVIOUR
//  Reset: state=IDLE; all VALID/READY outputs 0; req_ready 0; resp_valid 0; resp_rdata 0; resp_err 0;
//   captured addr/wdata/wstrb 0. Reset mid-transaction aborts it silently (system-wide reset).
//  Constants: ARLEN=AWLEN=0, ARSIZE=AWSIZE=3'b010, ARBURST=AWBURST=2'b01 (INCR), WLAST=1,
//   ARID=AWID=MASTER_ID. Address/data buses driven from capture registers at all times.
//  States: IDLE, RADDR, RDATA, WREQ, WRESP.
//  IDLE: req_ready=1. On req_valid: capture addr/wdata/wstrb; -> RADDR if !req_write else WREQ.
//  RADDR: ARVALID=1; on ARREADY -> RDATA.
//  RDATA: RREADY=1; on RVALID (first beat, RLAST ignored) -> IDLE; resp_rdata<=RDATA,
//   resp_err<=(RRESP!=0), resp_valid pulses next cycle.
//  WREQ: AWVALID=!aw_done, WVALID=!w_done; aw_done/w_done set on respective handshake (either order,
//   same cycle allowed). When both done (including handshakes this cycle) -> WRESP, flags cleared.
//  WRESP: BREADY=1; on BVALID -> IDLE; resp_err<=(BRESP!=0); resp_valid pulses next cycle; rdata held.
//  VALIDs depend only on registered state/flags, never on READY; once asserted held stable until handshake.
//  req_ready=1 only in IDLE; resp_valid cycle coincides with IDLE, so a new request may be accepted in
//   that same cycle (back-to-back, 1 idle cycle between AXI transactions minimum).
//  Latency with zero-wait slave: read req accepted cycle 0 -> ARVALID cycle 1 -> R handshake cycle 2 ->
//   resp_valid cycle 3. Write: AW+W cycle 1 -> B cycle 2 -> resp_valid cycle 3.
//  req_wstrb=0 still issues a full write transaction. Inputs ignored outside IDLE.
// TESTING
//  T1 read: req addr 0x0000_1004, ARREADY/RVALID immediate, RDATA 0xDEADBEEF -> ARADDR=0x1004,
//     resp_valid at cycle 3, resp_rdata=0xDEADBEEF, resp_err=0.
//  T2 write, AW and W ready same cycle: addr 0x2000, data 0x12345678, strb 4'b0011 -> single WREQ cycle,
//     WSTRB=0011, WLAST=1, BVALID next -> resp_valid, resp_err=0.
//  T3 write, WREADY 2 cycles before AWREADY (3-cycle AW stall) -> WVALID drops after W handshake,
//     AWVALID/AWADDR held stable until accepted, exactly one of each handshake.
//  T4 backpressure: ARREADY low 5 cycles -> ARVALID/ARADDR stable; RVALID delayed 4 cycles -> RREADY held 1.
//  T5 errors: RRESP=2'b10 on read, BRESP=2'b11 on write -> resp_err=1 with resp_valid each.
//  T6 RST asserted in RDATA and in WREQ -> all VALID/READY 0 same cycle; after release, T1 passes again;
//     back-to-back read then write accepted in resp_valid cycle.

Source files
------------

// File: rtl/axi_single_beat_master_if.sv
// -----------------------------------------------------------------------------
// axi_single_beat_master_if
// Purpose : bundles the simple memory request/response port and the five AXI4
//           channels (AR/R/AW/W/B) used by axi_single_beat_master.
// Ports   : none (signal container). Modports:
//           master - view of the bridge: drives req_ready/resp_*, AR*, RREADY,
//                    AW*, W*, BREADY; samples req_*, R*, ARREADY, AWREADY,
//                    WREADY, B*.
//           slave  - mirror view for whatever sits on the other side (CPU
//                    request source and AXI responder).
// Handshake: on every channel a transfer happens on the rising CLK edge where
//           VALID and READY are both 1. VALID never waits for READY, and once
//           raised it stays high with stable payload until that transfer.
// -----------------------------------------------------------------------------
interface axi_single_beat_master_if;
   // request / response side
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   // read address
   logic [3:0]  ARID;
   logic [31:0] ARADDR;
   logic [3:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic        ARVALID;
   logic        ARREADY;
   // read data
   logic [3:0]  RID;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY;
   // write address
   logic [3:0]  AWID;
   logic [31:0] AWADDR;
   logic [3:0]  AWLEN;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST;
   logic        AWVALID;
   logic        AWREADY;
   // write data
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WLAST;
   logic        WVALID;
   logic        WREADY;
   // write response
   logic [3:0]  BID;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      input  ARREADY,
      input  RID, RDATA, RRESP, RLAST, RVALID,
      output RREADY,
      output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      input  AWREADY,
      output WDATA, WSTRB, WLAST, WVALID,
      input  WREADY,
      input  BID, BRESP, BVALID,
      output BREADY
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      output ARREADY,
      output RID, RDATA, RRESP, RLAST, RVALID,
      input  RREADY,
      input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      output AWREADY,
      input  WDATA, WSTRB, WLAST, WVALID,
      output WREADY,
      output BID, BRESP, BVALID,
      input  BREADY
   );
endinterface

// File: rtl/axi_single_beat_master.sv
// -----------------------------------------------------------------------------
// axi_single_beat_master
// Purpose : turns a one-request-at-a-time memory port into single-beat AXI4
//           read (AR/R) or write (AW/W/B) transactions. At most one
//           transaction is outstanding.
// Ports   : CLK     - clock, rising edge
//           RST     - asynchronous, active-high reset
//           bus     - axi_single_beat_master_if.master (request/response port
//                     and all AXI channels)
//           state_o - current FSM state (0 IDLE, 1 RADDR, 2 RDATA, 3 WREQ,
//                     4 WRESP) for observation
// -----------------------------------------------------------------------------
module axi_single_beat_master #(
   parameter logic [3:0] MASTER_ID = 4'd0
) (
   input  logic                             CLK,
   input  logic                             RST,
   axi_single_beat_master_if.master         bus,
   output logic [2:0]                       state_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RADDR = 3'd1,
      S_RDATA = 3'd2,
      S_WREQ  = 3'd3,
      S_WRESP = 3'd4
   } state_e;

   state_e      state_q, state_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;

   logic        req_ready, arvalid, rready, awvalid, wvalid, bready;
   logic        aw_fin, w_fin;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= S_IDLE;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         wstrb_q      <= 4'd0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      req_ready    = 1'b0;
      arvalid      = 1'b0;
      rready       = 1'b0;
      awvalid      = 1'b0;
      wvalid       = 1'b0;
      bready       = 1'b0;
      aw_fin       = 1'b0;
      w_fin        = 1'b0;
      case (state_q)
         S_IDLE: begin
            // The reset state is IDLE, but nothing may be accepted while
            // reset is still held.
            req_ready = ~RST;
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               wstrb_d = bus.req_wstrb;
               state_d = bus.req_write ? S_WREQ : S_RADDR;
            end
         end
         S_RADDR: begin
            arvalid = 1'b1;
            if (bus.ARREADY) state_d = S_RDATA;
         end
         S_RDATA: begin
            rready = 1'b1;
            // Single-beat transfer: the first R beat completes it, RLAST is
            // not consulted.
            if (bus.RVALID) begin
               resp_valid_d = 1'b1;
               resp_rdata_d = bus.RDATA;
               resp_err_d   = (bus.RRESP != 2'b00);
               state_d      = S_IDLE;
            end
         end
         S_WREQ: begin
            awvalid = ~aw_done_q;
            wvalid  = ~w_done_q;
            // Either channel may finish first; a channel counts as finished
            // if it already was or handshakes in this cycle.
            aw_fin  = aw_done_q | (awvalid & bus.AWREADY);
            w_fin   = w_done_q  | (wvalid  & bus.WREADY);
            if (aw_fin && w_fin) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = S_WRESP;
            end else begin
               aw_done_d = aw_fin;
               w_done_d  = w_fin;
            end
         end
         S_WRESP: begin
            bready = 1'b1;
            if (bus.BVALID) begin
               resp_valid_d = 1'b1;
               resp_err_d   = (bus.BRESP != 2'b00);
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.req_ready  = req_ready;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;

   assign bus.ARID    = MASTER_ID;
   assign bus.ARADDR  = addr_q;
   assign bus.ARLEN   = 4'd0;
   assign bus.ARSIZE  = 3'b010;
   assign bus.ARBURST = 2'b01;
   assign bus.ARVALID = arvalid;
   assign bus.RREADY  = rready;

   assign bus.AWID    = MASTER_ID;
   assign bus.AWADDR  = addr_q;
   assign bus.AWLEN   = 4'd0;
   assign bus.AWSIZE  = 3'b010;
   assign bus.AWBURST = 2'b01;
   assign bus.AWVALID = awvalid;
   assign bus.WDATA   = wdata_q;
   assign bus.WSTRB   = wstrb_q;
   assign bus.WLAST   = 1'b1;
   assign bus.WVALID  = wvalid;
   assign bus.BREADY  = bready;

   assign state_o = state_q;

endmodule
